// File: rtl/rotary_encoder_gen.sv
// rotary_encoder_gen: quadrature rotary emulator driving rotA/rotB/rotCenter
// from single left/right/press/pause commands, with optional contact chatter.
module rotary_encoder_gen #(
    parameter int PHASE_CYCLES  = 75,
    parameter int PRESS_CYCLES  = 520,
    parameter int BOUNCE_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmdValid,
    input  logic [1:0] cmdCode,
    output logic       cmdReady,
    output logic       rotA,
    output logic       rotB,
    output logic       rotCenter,
    output logic       busy,
    output logic       done
);

    localparam int MAXC = (PHASE_CYCLES > PRESS_CYCLES) ? PHASE_CYCLES : PRESS_CYCLES;
    localparam int CW   = $clog2(MAXC);
    localparam logic [CW-1:0] PLAST = CW'(PHASE_CYCLES - 1);
    localparam logic [CW-1:0] RLAST = CW'(PRESS_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ROT, S_PRESS, S_REL, S_PAUSE, S_DONE
    } state_t;

    state_t        state, state_n;
    logic [1:0]    step, step_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          dir, dir_n;
    logic          last;
    logic          bz;
    logic          la, lb, ea;
    logic          a_n, b_n, c_n;
    logic          busy_n, done_n, rdy_n;

    // chatter bit for the edged signal: toggles on odd cycles inside the window
    generate
        if (BOUNCE_CYCLES > 0) begin : g_bounce
            assign bz = (cnt_n < CW'(BOUNCE_CYCLES)) & cnt_n[0];
        end else begin : g_clean
            assign bz = 1'b0;
        end
    endgenerate

    // state, step, phase counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            step      <= '0;
            cnt       <= '0;
            dir       <= 1'b0;
            rotA      <= 1'b0;
            rotB      <= 1'b0;
            rotCenter <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmdReady  <= 1'b0;
        end else begin
            state     <= state_n;
            step      <= step_n;
            cnt       <= cnt_n;
            dir       <= dir_n;
            rotA      <= a_n;
            rotB      <= b_n;
            rotCenter <= c_n;
            busy      <= busy_n;
            done      <= done_n;
            cmdReady  <= rdy_n;
        end
    end

    // next-state: command acceptance and step sequencing
    always_comb begin
        state_n = state;
        step_n  = step;
        cnt_n   = cnt + 1'b1;
        dir_n   = dir;
        last    = (cnt == ((state == S_PRESS) ? RLAST : PLAST));
        case (state)
            S_IDLE, S_DONE: begin
                cnt_n  = '0;
                step_n = '0;
                if (state == S_DONE) state_n = S_IDLE;
                if (cmdValid && cmdReady) begin
                    dir_n = (cmdCode == 2'b10);
                    unique case (cmdCode)
                        2'b00:   state_n = S_PAUSE;
                        2'b11:   state_n = S_PRESS;
                        default: state_n = S_ROT;
                    endcase
                end
            end
            S_ROT: begin
                if (last) begin
                    cnt_n = '0;
                    if (step == 2'd3) state_n = S_DONE;
                    else step_n = step + 2'd1;
                end
            end
            S_PRESS: begin
                if (last) begin
                    cnt_n   = '0;
                    state_n = S_REL;
                end
            end
            S_REL, S_PAUSE: begin
                if (last) begin
                    cnt_n   = '0;
                    state_n = S_DONE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // output levels derived from the upcoming state so they register cleanly
    always_comb begin
        a_n = 1'b0;
        b_n = 1'b0;
        c_n = 1'b0;
        la  = 1'b0;
        lb  = 1'b0;
        ea  = 1'b0;
        case (state_n)
            S_ROT: begin
                if (!dir_n) begin
                    la = ~step_n[1];
                    lb = step_n[0] ^ step_n[1];
                    ea = ~step_n[0];
                end else begin
                    la = step_n[0] ^ step_n[1];
                    lb = ~step_n[1];
                    ea = step_n[0];
                end
                a_n = la ^ (ea & bz);
                b_n = lb ^ (~ea & bz);
            end
            S_PRESS: c_n = ~bz;
            S_REL:   c_n = bz;
            default: c_n = 1'b0;
        endcase
        busy_n = (state_n == S_ROT) || (state_n == S_PRESS) ||
                 (state_n == S_REL) || (state_n == S_PAUSE);
        done_n = (state_n == S_DONE);
        rdy_n  = (state_n == S_IDLE) || (state_n == S_DONE);
    end

endmodule

// File: tb/tb_rotary_encoder_gen.sv
// tb_rotary_encoder_gen: directed commands with a cycle-indexed scoreboard
// and a small quadrature decoder model watching the outputs.
module tb_rotary_encoder_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       vld;
    logic [1:0] code;
    logic rdy0, a0, b0, c0, busy0, done0;
    logic rdy1, a1, b1, c1, busy1, done1;

    always #10 clk = ~clk;

    rotary_encoder_gen u0 (
        .clk(clk), .rst(rst), .cmdValid(vld), .cmdCode(code),
        .cmdReady(rdy0), .rotA(a0), .rotB(b0), .rotCenter(c0),
        .busy(busy0), .done(done0)
    );

    rotary_encoder_gen #(.BOUNCE_CYCLES(4)) u1 (
        .clk(clk), .rst(rst), .cmdValid(vld), .cmdCode(code),
        .cmdReady(rdy1), .rotA(a1), .rotB(b1), .rotCenter(c1),
        .busy(busy1), .done(done1)
    );

    typedef struct {
        int   cyc;
        int   sig;
        logic val;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    string sn[8] = '{"rotA", "rotB", "rotCenter", "busy", "done", "cmdReady", "bncA", "bncB"};

    // quadrature decoder model: counts full detents per instance
    logic [1:0] cur[2];
    logic [1:0] prv[2] = '{2'b00, 2'b00};
    int pos[2] = '{0, 0};
    int nl[2] = '{0, 0};
    int nr[2] = '{0, 0};

    assign cur[0] = {a0, b0};
    assign cur[1] = {a1, b1};

    function automatic int qidx(logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int qd(logic [1:0] o, logic [1:0] n);
        int t;
        t = (qidx(n) - qidx(o)) & 3;
        return (t == 1) ? 1 : ((t == 3) ? -1 : 0);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                pos[i] <= 0;
                prv[i] <= 2'b00;
            end else begin
                if (qidx(cur[i]) == 0 && pos[i] + qd(prv[i], cur[i]) >= 4) begin
                    nl[i]  <= nl[i] + 1;
                    pos[i] <= 0;
                end else if (qidx(cur[i]) == 0 && pos[i] + qd(prv[i], cur[i]) <= -4) begin
                    nr[i]  <= nr[i] + 1;
                    pos[i] <= 0;
                end else begin
                    pos[i] <= pos[i] + qd(prv[i], cur[i]);
                end
                prv[i] <= cur[i];
            end
        end
    end

    function automatic logic obs(int s);
        case (s)
            0: return a0;
            1: return b0;
            2: return c0;
            3: return busy0;
            4: return done0;
            5: return rdy0;
            6: return a1;
            default: return b1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic o, input logic e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s got=%b want=%b", tag, o, e);
        end
    endtask

    task automatic chki(input string tag, input int o, input int e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, o, e);
        end
    endtask

    task automatic ex(input int c, input int s, input logic v);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                chk($sformatf("%s@%0d", sn[q[i].sig], cyc), obs(q[i].sig), q[i].val);
                q.delete(i);
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic all_low(input string tag, input logic r);
        chk({tag, "_rotA"}, a0, 1'b0);
        chk({tag, "_rotB"}, b0, 1'b0);
        chk({tag, "_rotCenter"}, c0, 1'b0);
        chk({tag, "_busy"}, busy0, 1'b0);
        chk({tag, "_done"}, done0, 1'b0);
        chk({tag, "_cmdReady"}, rdy0, r);
    endtask

    int bl0, br0, bl1;

    initial begin
        rst  = 1'b0;
        vld  = 1'b0;
        code = 2'b00;
        repeat (3) @(negedge clk);
        all_low("reset", 1'b0);

        // release with valid already high: must not be taken on the release edge
        rst  = 1'b1;
        vld  = 1'b1;
        code = 2'b01;
        @(posedge clk);
        @(negedge clk);
        chk("rel_ready", rdy0, 1'b1);
        chk("rel_busy", busy0, 1'b0);
        chk("rel_rotA", a0, 1'b0);

        // left rotation, plus the chattering instance
        cyc = 0;
        ex(1, 0, 1'b1); ex(1, 1, 1'b0); ex(1, 3, 1'b1); ex(1, 5, 1'b0);
        ex(75, 0, 1'b1); ex(75, 1, 1'b0); ex(76, 1, 1'b1);
        ex(150, 0, 1'b1); ex(151, 0, 1'b0); ex(225, 1, 1'b1);
        ex(226, 1, 1'b0); ex(300, 3, 1'b1); ex(300, 4, 1'b0);
        ex(301, 4, 1'b1); ex(301, 3, 1'b0); ex(301, 5, 1'b1);
        ex(302, 4, 1'b0); ex(302, 5, 1'b1);
        ex(1, 6, 1'b1); ex(2, 6, 1'b0); ex(3, 6, 1'b1); ex(4, 6, 1'b0);
        ex(5, 6, 1'b1); ex(40, 6, 1'b1);
        for (int k = 1; k <= 5; k++) ex(k, 7, 1'b0);
        ex(76, 7, 1'b1); ex(77, 7, 1'b0); ex(78, 7, 1'b1);
        ex(79, 7, 1'b0); ex(80, 7, 1'b1);
        tick();
        vld = 1'b0;
        run(304);
        chki("left_drained", q.size(), 0);
        chki("left_dec_left", nl[0], 1);
        chki("left_dec_right", nr[0], 0);
        chki("bnc_dec_left", nl[1], 1);
        chki("bnc_dec_right", nr[1], 0);

        // right rotation
        vld  = 1'b1;
        code = 2'b10;
        cyc  = 0;
        ex(1, 1, 1'b1); ex(1, 0, 1'b0); ex(75, 0, 1'b0); ex(76, 0, 1'b1);
        ex(151, 1, 1'b0); ex(226, 0, 1'b0); ex(300, 4, 1'b0);
        ex(301, 4, 1'b1); ex(301, 3, 1'b0);
        tick();
        vld = 1'b0;
        run(304);
        chki("right_drained", q.size(), 0);
        chki("right_dec_right", nr[0], 1);
        chki("right_dec_left", nl[0], 1);

        // press
        vld  = 1'b1;
        code = 2'b11;
        cyc  = 0;
        ex(1, 2, 1'b1); ex(1, 0, 1'b0); ex(1, 3, 1'b1);
        ex(260, 2, 1'b1); ex(520, 2, 1'b1); ex(521, 2, 1'b0);
        ex(521, 3, 1'b1); ex(595, 3, 1'b1); ex(595, 4, 1'b0);
        ex(596, 4, 1'b1); ex(596, 3, 1'b0); ex(596, 2, 1'b0);
        tick();
        vld = 1'b0;
        run(604);
        chki("press_drained", q.size(), 0);

        // left then pause with valid held: pause taken on the DONE cycle
        bl0  = nl[0];
        vld  = 1'b1;
        code = 2'b01;
        cyc  = 0;
        ex(150, 5, 1'b0); ex(301, 4, 1'b1); ex(301, 5, 1'b1);
        ex(302, 3, 1'b1); ex(302, 5, 1'b0); ex(302, 4, 1'b0);
        ex(302, 0, 1'b0); ex(302, 1, 1'b0); ex(350, 0, 1'b0);
        ex(350, 1, 1'b0); ex(376, 3, 1'b1); ex(376, 4, 1'b0);
        ex(377, 4, 1'b1); ex(377, 3, 1'b0); ex(378, 4, 1'b0);
        tick();
        code = 2'b00;
        run(301);
        vld = 1'b0;
        run(80);
        chki("b2b_drained", q.size(), 0);
        chki("b2b_dec_left", nl[0] - bl0, 1);

        // reset in the middle of a left command
        bl0  = nl[0];
        br0  = nr[0];
        bl1  = nl[1];
        vld  = 1'b1;
        code = 2'b01;
        cyc  = 0;
        ex(100, 0, 1'b1); ex(100, 1, 1'b1);
        tick();
        vld = 1'b0;
        run(99);
        #3 rst = 1'b0;
        #1 all_low("midrst", 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("midrst_hold_done", done0, 1'b0);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_ready", rdy0, 1'b1);
        chk("post_rst_done", done0, 1'b0);
        vld  = 1'b1;
        code = 2'b10;
        cyc  = 0;
        ex(1, 1, 1'b1); ex(1, 0, 1'b0); ex(76, 0, 1'b1);
        ex(301, 4, 1'b1); ex(302, 4, 1'b0);
        tick();
        vld = 1'b0;
        run(304);
        chki("rst_drained", q.size(), 0);
        chki("rst_dec_right", nr[0] - br0, 1);
        chki("rst_dec_left", nl[0] - bl0, 0);
        chki("rst_bnc_left", nl[1] - bl1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
